i2s_rx_deserializer: RTL and testbench
======================================

Name: i2s_rx_deserializer

Overview:
- I2S receiver. Consumes the BCLK/LRCLK/SD serial stream produced against the team's I2S clock generator, or by an external codec such as an ADC.
- Deserializes MSB-first, one-bit-delayed (Philips I2S) frames into parallel left/right sample pairs.
- Presents each pair to the DSP datapath with a valid/ready handshake.
- Runs entirely in the 50 MHz system clock domain. The I2S lines are asynchronous inputs and are oversampled.

Parameters:
- DATA_W, 24: sample width in bits, per channel.
- SYNC_STAGES, 2: synchronizer flop depth on each I2S input (minimum 2).

Ports:
- clk  in  1  system clock, 50 MHz; must be >= 4x the BCLK frequency.
- rst_n  in  1  asynchronous, active-low reset.
- i2s_bclk  in  1  bit clock, asynchronous to clk.
- i2s_lrclk  in  1  word select: 0 = left, 1 = right; asynchronous.
- i2s_sd  in  1  serial data, asynchronous.
- left_data  out  DATA_W  left sample of the current pair.
- right_data  out  DATA_W  right sample of the current pair.
- sample_valid  out  1  the pair on left_data/right_data is valid.
- sample_ready  in  1  consumer accepts the pair.
- overrun  out  1  one-cycle pulse: an unaccepted pair was overwritten.

Behaviour:
- Reset: all outputs 0, shift register 0, bit counter 0, FSM in WAIT_SYNC. Reset is asynchronous. Asserting it mid-frame discards the partial word and any pending pair.
- Synchronization: bclk, lrclk and sd each pass through SYNC_STAGES flops, so all three carry identical delay.
- bit_tick: a 1-cycle strobe when the synchronized bclk is 1 and its previous value was 0.
- All protocol actions happen only on cycles where bit_tick is high.
- Boundary: at bit_tick, the sampled lrclk differs from the lrclk value captured at the previous bit_tick.
- I2S timing: the SD bit sampled on the boundary tick is the LSB slot of the old channel. The MSB of the new channel is sampled on the next tick.
- FSM states and transitions:
  - WAIT_SYNC: ignore data until a 1->0 boundary (left start) is seen, then go to SHIFT with bit count 0.
  - SHIFT: on each non-boundary tick, shift sd into the LSB of the shift register and increment the bit count. When the count reaches DATA_W, go to HOLD.
  - HOLD: extra bits are ignored until the next boundary (word longer than DATA_W).
  - Boundary tick in SHIFT: shift the bit in (if count < DATA_W), commit the word, return to SHIFT with count 0.
  - Boundary tick in HOLD: commit the word, return to SHIFT with count 0.
- Short words (count < DATA_W at commit): left-justify, i.e. shift left by (DATA_W - count) with zero fill. Example: a 16-bit word 0xABCD with DATA_W=24 gives 0xABCD00.
- Commit on a 1->0 boundary: the committed word is right_data. Publish the pair {left_latched, right_data}.
- Commit on a 0->1 boundary: the committed word is stored as left_latched.
- Publish timing: sample_valid goes high on the clk edge after the commit tick. Total latency from the raw bclk rising edge to sample_valid is SYNC_STAGES+2 clk cycles.
- Handshake:
  - The pair is accepted on the cycle where sample_valid and sample_ready are both 1.
  - sample_valid drops the next cycle unless a new publish happens on that same cycle.
  - left_data/right_data are stable while sample_valid is high and not yet accepted.
- Overrun: a publish while sample_valid=1 and sample_ready=0 overwrites the data, keeps sample_valid=1, and pulses overrun for 1 cycle.
- Simultaneous events: if accept and publish occur on the same cycle, the new pair is loaded, sample_valid stays 1, and there is no overrun.
- The first publish after reset or sync requires a complete left word followed by a complete right word. A right word with no preceding left word in the same sync is dropped.
- Bit counter: width $clog2(DATA_W+1); saturates at DATA_W.

Decomposition:
- Package i2s_pkg holds:
  - the FSM state enum (WAIT_SYNC, SHIFT, HOLD);
  - the default word width localparam (24);
  - the default sample rate localparam (48 kHz).
  The clock generator and this receiver both import it.
- Sub-module i2s_sync_edge: parameterized SYNC_STAGES synchronizer plus a registered previous value. It outputs the synced level, a rise strobe and a change strobe. One instance is used for bclk; lrclk and sd use the level output only.

Test Plan:
- Nominal frame: after reset, drive BCLK = 2.08 MHz, left=0x123456, right=0xABCDEF, sample_ready=1 -> exactly one sample_valid pulse with left_data=0x123456, right_data=0xABCDEF, at SYNC_STAGES+2 clk after the right-word commit bclk edge.
- Back-pressure: send 2 frames (0x000001/0x000002, then 0x0000AA/0x0000BB) with sample_ready=0 -> overrun pulses once at the second publish; data shows 0xAA/0xBB; sample_valid remains 1 until ready is asserted, then drops in 1 cycle.
- Short and long words:
  - 16-bit words 0xABCD/0x1234 -> 0xABCD00/0x123400.
  - 32-bit words 0xFFEEDDCC/0x11223344 -> 0xFFEEDD/0x112233.
- Sync: start the stream mid right-channel, with lrclk=1 at reset release -> no valid output until a full left+right pair follows; the first pair matches the driven values.
- Reset mid-frame: assert rst_n=0 halfway through the left word -> outputs 0 immediately. After release, the next complete frame 0x5A5A5A/0xA5A5A5 is reported correctly and the partial frame is never output.
- Accept+publish collision: sample_ready rises on the exact cycle of a new publish -> no overrun, new pair held, sample_valid continuous.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver FSM states and default stream geometry.
package i2s_pkg;

   localparam int I2S_DATA_W      = 24;
   localparam int I2S_SAMPLE_RATE = 48000;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      SHIFT     = 2'd1,
      HOLD      = 2'd2
   } i2s_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line, with a registered copy of
// the synced level so rising and any-change strobes can be derived.
module i2s_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic change
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // Synchronizer chain plus one extra flop holding the previous synced level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign level  = chain[SYNC_STAGES-1];
   assign rise   = level & ~prev;
   assign change = level ^ prev;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// Philips I2S receiver: oversamples BCLK/LRCLK/SD in the system clock domain,
// deserializes MSB-first left/right words and hands out pairs via valid/ready.
module i2s_rx_deserializer
   import i2s_pkg::*;
#(
   parameter int DATA_W      = I2S_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i2s_bclk,
   input  logic                     i2s_lrclk,
   input  logic                     i2s_sd,
   output logic signed [DATA_W-1:0] left_data,
   output logic signed [DATA_W-1:0] right_data,
   output logic                     sample_valid,
   input  logic                     sample_ready,
   output logic                     overrun
);

   localparam int               CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DATA_W);

   // Word received with fewer than DATA_W bits sits right-aligned in the
   // shift register; move it to the top and zero-fill below.
   function automatic logic [DATA_W-1:0] justify(input logic [DATA_W-1:0] word,
                                                 input logic [CNT_W-1:0]  nbits);
      logic [CNT_W-1:0] pad;
      pad = FULL - nbits;
      return word << pad;
   endfunction

   logic bclk_rise;
   logic unused_bclk_level, unused_bclk_change;
   logic lr_sync, unused_lr_rise, unused_lr_change;
   logic sd_sync, unused_sd_rise, unused_sd_change;

   i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
      .clk(clk), .rst_n(rst_n), .din(i2s_bclk),
      .level(unused_bclk_level), .rise(bclk_rise), .change(unused_bclk_change)
   );

   i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
      .clk(clk), .rst_n(rst_n), .din(i2s_lrclk),
      .level(lr_sync), .rise(unused_lr_rise), .change(unused_lr_change)
   );

   i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
      .clk(clk), .rst_n(rst_n), .din(i2s_sd),
      .level(sd_sync), .rise(unused_sd_rise), .change(unused_sd_change)
   );

   logic tick_p0, lr_p0, sd_p0;

   // Stage p0: register the bit tick together with the LRCLK/SD levels it samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_p0 <= 1'b0;
         lr_p0   <= 1'b0;
         sd_p0   <= 1'b0;
      end else begin
         tick_p0 <= bclk_rise;
         lr_p0   <= lr_sync;
         sd_p0   <= sd_sync;
      end
   end

   i2s_state_t                 state;
   logic        [DATA_W-1:0]   shreg;
   logic        [CNT_W-1:0]    cnt;
   logic                       lr_prev;
   logic signed [DATA_W-1:0]   left_latched;
   logic                       have_left;

   logic                       boundary;
   logic                       publish;
   logic                       accept;
   logic        [DATA_W-1:0]   shifted;
   logic        [DATA_W-1:0]   commit_word;

   assign boundary = tick_p0 && (lr_p0 != lr_prev);
   assign shifted  = {shreg[DATA_W-2:0], sd_p0};
   assign publish  = boundary && !lr_p0 && have_left && (state != WAIT_SYNC);
   assign accept   = sample_valid && sample_ready;

   // Word being committed on a boundary tick: the LSB slot bit still counts
   // unless the word already overflowed into HOLD.
   always_comb begin
      commit_word = '0;
      if (state == HOLD) begin
         commit_word = justify(shreg, FULL);
      end else if (cnt < FULL) begin
         commit_word = justify(shifted, cnt + CNT_W'(1));
      end else begin
         commit_word = justify(shreg, cnt);
      end
   end

   // Stage p1: framing FSM, shift register, bit counter and left-word latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= WAIT_SYNC;
         shreg        <= '0;
         cnt          <= '0;
         lr_prev      <= 1'b0;
         left_latched <= '0;
         have_left    <= 1'b0;
      end else if (tick_p0) begin
         lr_prev <= lr_p0;
         case (state)
            WAIT_SYNC: begin
               if (boundary && !lr_p0) begin
                  state     <= SHIFT;
                  shreg     <= '0;
                  cnt       <= '0;
                  have_left <= 1'b0;
               end
            end
            SHIFT, HOLD: begin
               if (boundary) begin
                  state <= SHIFT;
                  shreg <= '0;
                  cnt   <= '0;
                  if (lr_p0) begin
                     left_latched <= commit_word;
                     have_left    <= 1'b1;
                  end else begin
                     have_left    <= 1'b0;
                  end
               end else if (state == SHIFT) begin
                  shreg <= shifted;
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt + CNT_W'(1) == FULL) begin
                     state <= HOLD;
                  end
               end
            end
            default: state <= WAIT_SYNC;
         endcase
      end
   end

   // Stage p2: output pair register with valid/ready handshake and overrun pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_data    <= '0;
         right_data   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (publish) begin
            left_data    <= left_latched;
            right_data   <= commit_word;
            sample_valid <= 1'b1;
            overrun      <= sample_valid && !sample_ready;
         end else if (accept) begin
            sample_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: drives Philips I2S frames at ~2.08 MHz BCLK
// and compares accepted pairs against word values computed from the frames.
module tb_i2s_rx_deserializer;

   localparam int DATA_W      = 24;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 12;   // clk cycles per BCLK half period

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     i2s_bclk = 1'b0;
   logic                     i2s_lrclk = 1'b0;
   logic                     i2s_sd = 1'b0;
   logic signed [DATA_W-1:0] left_data;
   logic signed [DATA_W-1:0] right_data;
   logic                     sample_valid;
   logic                     sample_ready = 1'b0;
   logic                     overrun;

   i2s_rx_deserializer #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .rst_n(rst_n),
      .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sd(i2s_sd),
      .left_data(left_data), .right_data(right_data),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .overrun(overrun)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // capture of DUT activity (accepted pairs, overrun cycles, valid rises)
   logic [47:0] obs_q[$];
   int          ovr_cnt = 0;
   int          vrise_cnt = 0;
   int          vrise_cyc = 0;
   logic        valid_d = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (sample_valid && sample_ready) obs_q.push_back({left_data, right_data});
         if (overrun) ovr_cnt <= ovr_cnt + 1;
         if (sample_valid && !valid_d) begin
            vrise_cnt <= vrise_cnt + 1;
            vrise_cyc <= cyc;
         end
         valid_d <= sample_valid;
      end else begin
         valid_d <= 1'b0;
      end
   end

   initial begin
      #1800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Justified DATA_W-bit sample for a w-bit I2S word: short words are scaled
   // up by a power of two, long words keep their top DATA_W bits.
   function automatic logic [23:0] ref_justify(input logic [31:0] v, input int w);
      logic [63:0] x;
      if (w <= 24) x = 64'(v) * 64'(2 ** (24 - w));
      else         x = 64'(v) / 64'(2 ** (w - 24));
      return x[23:0];
   endfunction

   function automatic logic [31:0] width_mask(input int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return m[31:0];
   endfunction

   // ---------------- stream driver ----------------
   logic pend = 1'b0;          // LSB of the previous slot, sent in the next slot
   int   commit_rise_cyc = 0;  // cyc at the raw BCLK rise starting a left slot

   task automatic drive_period(input logic lr, input logic b, input logic mark);
      i2s_bclk  = 1'b0;
      i2s_lrclk = lr;
      i2s_sd    = b;
      repeat (HALF) @(negedge clk);
      i2s_bclk = 1'b1;
      if (mark) commit_rise_cyc = cyc;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send_slot(input logic lr, input logic [31:0] word, input int width,
                            input int nper);
      logic b;
      for (int i = 0; i < nper; i++) begin
         b = (i == 0) ? pend : word[width - i];
         drive_period(lr, b, (i == 0) && (lr == 1'b0));
      end
      pend = word[0];
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int w);
      send_slot(1'b0, l, w, w);
      send_slot(1'b1, r, w, w);
   endtask

   task automatic lead_in();
      pend = 1'b0;
      send_slot(1'b1, 32'h0, 24, 24);
   endtask

   task automatic flush();
      send_slot(1'b0, 32'h0, 24, 4);
      repeat (8) @(negedge clk);
   endtask

   task automatic apply_reset(input logic lr_init, input logic rdy);
      rst_n        = 1'b0;
      i2s_bclk     = 1'b0;
      i2s_lrclk    = lr_init;
      i2s_sd       = 1'b0;
      sample_ready = rdy;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      obs_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset(1'b0, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
      checks++; if (left_data !== 24'h0) begin errors++; $display("FAIL reset_left got %h want 000000", left_data); end
      checks++; if (right_data !== 24'h0) begin errors++; $display("FAIL reset_right got %h want 000000", right_data); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_nominal();
      int vb, ob;
      apply_reset(1'b0, 1'b1);
      vb = vrise_cnt; ob = ovr_cnt;
      lead_in();
      send_frame(32'h123456, 32'hABCDEF, 24);
      flush();
      checks++; if (vrise_cnt - vb !== 1) begin errors++; $display("FAIL nominal_pulses got %0d want 1", vrise_cnt - vb); end
      checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL nominal_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         checks++; if (obs_q[0] !== {24'h123456, 24'hABCDEF}) begin errors++; $display("FAIL nominal_pair got %h want %h", obs_q[0], {24'h123456, 24'hABCDEF}); end
      end
      checks++; if (vrise_cyc - commit_rise_cyc !== SYNC_STAGES + 2) begin errors++; $display("FAIL nominal_latency got %0d want %0d", vrise_cyc - commit_rise_cyc, SYNC_STAGES + 2); end
      checks++; if (ovr_cnt - ob !== 0) begin errors++; $display("FAIL nominal_overrun got %0d want 0", ovr_cnt - ob); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL nominal_valid_drop got %b want 0", sample_valid); end
   endtask

   task automatic test_back_pressure();
      int ob;
      apply_reset(1'b0, 1'b0);
      ob = ovr_cnt;
      lead_in();
      send_frame(32'h000001, 32'h000002, 24);
      send_frame(32'h0000AA, 32'h0000BB, 24);
      flush();
      checks++; if (ovr_cnt - ob !== 1) begin errors++; $display("FAIL bp_overrun got %0d want 1", ovr_cnt - ob); end
      checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held got %b want 1", sample_valid); end
      checks++; if (left_data !== 24'h0000AA) begin errors++; $display("FAIL bp_left got %h want 0000aa", left_data); end
      checks++; if (right_data !== 24'h0000BB) begin errors++; $display("FAIL bp_right got %h want 0000bb", right_data); end
      checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL bp_no_accept got %0d want 0", obs_q.size()); end
      @(posedge clk); #2 sample_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b want 0", sample_valid); end
      checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL bp_accept_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         checks++; if (obs_q[0] !== {24'h0000AA, 24'h0000BB}) begin errors++; $display("FAIL bp_accept_pair got %h want %h", obs_q[0], {24'h0000AA, 24'h0000BB}); end
      end
      @(negedge clk);
   endtask

   task automatic test_word_lengths();
      logic [47:0] exp_q[$];
      apply_reset(1'b0, 1'b1);
      exp_q.push_back({ref_justify(32'hABCD, 16), ref_justify(32'h1234, 16)});
      exp_q.push_back({ref_justify(32'hFFEEDDCC, 32), ref_justify(32'h11223344, 32)});
      lead_in();
      send_frame(32'hABCD, 32'h1234, 16);
      send_frame(32'hFFEEDDCC, 32'h11223344, 32);
      flush();
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL len_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL len_pair%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_sync();
      int vb;
      logic [31:0] l, r;
      l = $urandom & 32'hFFFFFF;
      r = $urandom & 32'hFFFFFF;
      apply_reset(1'b1, 1'b1);
      vb = vrise_cnt;
      pend = 1'b0;
      send_slot(1'b1, $urandom, 24, 10);
      send_slot(1'b0, l, 24, 24);
      checks++; if (vrise_cnt - vb !== 0) begin errors++; $display("FAIL sync_early_valid got %0d want 0", vrise_cnt - vb); end
      send_slot(1'b1, r, 24, 24);
      flush();
      checks++; if (vrise_cnt - vb !== 1) begin errors++; $display("FAIL sync_pulses got %0d want 1", vrise_cnt - vb); end
      checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL sync_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         checks++; if (obs_q[0] !== {ref_justify(l, 24), ref_justify(r, 24)}) begin errors++; $display("FAIL sync_pair got %h want %h", obs_q[0], {ref_justify(l, 24), ref_justify(r, 24)}); end
      end
   endtask

   task automatic test_reset_mid_frame();
      apply_reset(1'b0, 1'b0);
      lead_in();
      send_frame($urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF, 24);
      send_slot(1'b0, 32'h00C3C3C3, 24, 12);
      checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b want 1", sample_valid); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", sample_valid); end
      checks++; if (left_data !== 24'h0) begin errors++; $display("FAIL rstmid_left got %h want 000000", left_data); end
      checks++; if (right_data !== 24'h0) begin errors++; $display("FAIL rstmid_right got %h want 000000", right_data); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sample_ready = 1'b1;
      obs_q.delete();
      @(negedge clk);
      send_slot(1'b1, 32'h003C3C3C, 24, 24);
      send_frame(32'h5A5A5A, 32'hA5A5A5, 24);
      flush();
      checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL rstmid_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         checks++; if (obs_q[0] !== {24'h5A5A5A, 24'hA5A5A5}) begin errors++; $display("FAIL rstmid_pair got %h want %h", obs_q[0], {24'h5A5A5A, 24'hA5A5A5}); end
      end
   endtask

   task automatic test_collision();
      int ob, vb;
      logic [23:0] l1, r1, l2, r2;
      l1 = $urandom; r1 = $urandom; l2 = $urandom; r2 = $urandom;
      apply_reset(1'b0, 1'b0);
      ob = ovr_cnt; vb = vrise_cnt;
      lead_in();
      send_frame(32'(l1), 32'(r1), 24);
      send_frame(32'(l2), 32'(r2), 24);
      // boundary period that commits the second right word
      i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sd = pend;
      repeat (HALF) @(negedge clk);
      i2s_bclk = 1'b1;
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #2;
      checks++; if ({sample_valid, left_data, right_data} !== {1'b1, l1, r1}) begin errors++; $display("FAIL coll_pre got %h want %h", {sample_valid, left_data, right_data}, {1'b1, l1, r1}); end
      sample_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coll_overrun got %b want 0", overrun); end
      checks++; if ({sample_valid, left_data, right_data} !== {1'b1, l2, r2}) begin errors++; $display("FAIL coll_new_pair got %h want %h", {sample_valid, left_data, right_data}, {1'b1, l2, r2}); end
      @(posedge clk); #1;
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL coll_valid_drop got %b want 0", sample_valid); end
      repeat (HALF) @(negedge clk);
      checks++; if (ovr_cnt - ob !== 0) begin errors++; $display("FAIL coll_overrun_total got %0d want 0", ovr_cnt - ob); end
      checks++; if (vrise_cnt - vb !== 1) begin errors++; $display("FAIL coll_valid_continuous got %0d want 1", vrise_cnt - vb); end
      checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL coll_count got %0d want 2", obs_q.size()); end
      if (obs_q.size() == 2) begin
         checks++; if (obs_q[0] !== {l1, r1}) begin errors++; $display("FAIL coll_first got %h want %h", obs_q[0], {l1, r1}); end
         checks++; if (obs_q[1] !== {l2, r2}) begin errors++; $display("FAIL coll_second got %h want %h", obs_q[1], {l2, r2}); end
      end
   endtask

   task automatic test_back_to_back();
      logic [47:0] exp_q[$];
      logic [31:0] l, r;
      int          w;
      apply_reset(1'b0, 1'b1);
      lead_in();
      for (int f = 0; f < 6; f++) begin
         w = $urandom_range(32, 8);
         l = $urandom & width_mask(w);
         r = $urandom & width_mask(w);
         exp_q.push_back({ref_justify(l, w), ref_justify(r, w)});
         send_frame(l, r, w);
      end
      flush();
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_pair%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_nominal();
      test_back_pressure();
      test_word_lengths();
      test_sync();
      test_reset_mid_frame();
      test_collision();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
